// File: rtl/fir_st_feeder.sv
// fir_st_feeder: Avalon-ST feeder that captures strobed signed samples into a
// small circular FIFO and presents them, one per handshake, through an output
// register toward the FIR filter's sink port. Dropped samples are counted.
// Optional feature macro: FEEDER_ERROR_EN -- when defined, the first word
// loaded into the output register after a drop carries ast_source_error=2'b01.
module fir_st_feeder #(
  parameter int DATA_W     = 12,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_en,
  input  logic [DATA_W-1:0]     sample_in,
  input  logic                  ast_source_ready,
  output logic                  ast_source_valid,
  output logic [DATA_W-1:0]     ast_source_data,
  output logic [1:0]            ast_source_error,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [7:0]            overflow_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [DATA_W-1:0]     fifoMem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [1:0]            error_q, error_d;
  logic [7:0]            ovfCnt_q, ovfCnt_d;
`ifdef FEEDER_ERROR_EN
  logic                  pending_q, pending_d;
`endif

  logic canLoad;
  logic doPop;
  logic doPush;
  logic doDrop;
  logic fifoFull;

  // The count can never exceed DEPTH, so its top bit alone means "full".
  assign fifoFull = count_q[DEPTH_LOG2];

  // Handshake decisions and next-state for pointers, count, output register
  // and the saturating drop counter.
  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    data_d   = data_q;
    error_d  = error_q;
    ovfCnt_d = ovfCnt_q;
`ifdef FEEDER_ERROR_EN
    pending_d = pending_q;
`endif

    canLoad = !valid_q || ast_source_ready;
    doPop   = canLoad && (count_q != '0);
    doPush  = sample_en && (!fifoFull || doPop);
    doDrop  = sample_en && !doPush;

    if (canLoad) begin
      valid_d = doPop;
      if (doPop) begin
        data_d  = fifoMem_q[rdPtr_q];
        rdPtr_d = rdPtr_q + DEPTH_LOG2'(1);
      end
    end

    if (doPush) begin
      wrPtr_d = wrPtr_q + DEPTH_LOG2'(1);
    end

    count_d = count_q + CW'(doPush) - CW'(doPop);

    if (doDrop && (ovfCnt_q != 8'hFF)) begin
      ovfCnt_d = ovfCnt_q + 8'd1;
    end

`ifdef FEEDER_ERROR_EN
    if (doPop) begin
      error_d   = pending_q ? 2'b01 : 2'b00;
      pending_d = 1'b0;
    end
    if (doDrop) begin
      pending_d = 1'b1;
    end
`endif
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      error_q  <= 2'b00;
      ovfCnt_q <= 8'd0;
`ifdef FEEDER_ERROR_EN
      pending_q <= 1'b0;
`endif
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      error_q  <= error_d;
      ovfCnt_q <= ovfCnt_d;
`ifdef FEEDER_ERROR_EN
      pending_q <= pending_d;
`endif
    end
  end

  // Sample storage; stale contents after reset are unreachable because the
  // pointers and count restart from zero.
  always_ff @(posedge clk) begin
    if (doPush) begin
      fifoMem_q[wrPtr_q] <= sample_in;
    end
  end

  assign ast_source_valid = valid_q;
  assign ast_source_data  = data_q;
  assign ast_source_error = error_q;
  assign fifo_level       = count_q;
  assign overflow_cnt     = ovfCnt_q;

endmodule

// File: tb/tb_fir_st_feeder.sv
// tb_fir_st_feeder: randomized and directed stimulus for fir_st_feeder with a
// queue-based reference model and a scoreboard checked by a separate monitor.
module tb_fir_st_feeder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_en = 1'b0;
  logic [11:0] sample_in = '0;
  logic        ast_source_ready = 1'b0;
  logic        ast_source_valid;
  logic [11:0] ast_source_data;
  logic [1:0]  ast_source_error;
  logic [3:0]  fifo_level;
  logic [7:0]  overflow_cnt;

  int testsRun = 0;
  int testsFailed = 0;
  bit monOn = 1'b0;

  // Reference model state: samples waiting in the FIFO and the presented word.
  logic [11:0] mFifo[$];
  logic [13:0] sb[$];
  bit          mValid = 1'b0;
  logic [11:0] mData = '0;
  logic [1:0]  mErr = 2'b00;
  int          mOvf = 0;
  bit          mPend = 1'b0;
  bit          canLoad, doPop, doPush, doDrop;

  fir_st_feeder #(.DATA_W(12), .DEPTH_LOG2(3)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sample_en        (sample_en),
    .sample_in        (sample_in),
    .ast_source_ready (ast_source_ready),
    .ast_source_valid (ast_source_valid),
    .ast_source_data  (ast_source_data),
    .ast_source_error (ast_source_error),
    .fifo_level       (fifo_level),
    .overflow_cnt     (overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit en, input logic [11:0] d, input bit rdy);
    sample_en        = en;
    sample_in        = d;
    ast_source_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: buffer of 8 plus a presentation slot; every word that
  // enters the slot is queued for the monitor with its expected error code.
  always @(posedge clk) begin
    if (!reset_n) begin
      mFifo.delete();
      sb.delete();
      mValid = 1'b0;
      mData  = '0;
      mErr   = 2'b00;
      mOvf   = 0;
      mPend  = 1'b0;
    end else begin
      canLoad = !mValid || ast_source_ready;
      doPop   = canLoad && (mFifo.size() > 0);
      doPush  = sample_en && ((mFifo.size() < 8) || doPop);
      doDrop  = sample_en && !doPush;
      if (canLoad) begin
        if (doPop) begin
          mData  = mFifo.pop_front();
          mValid = 1'b1;
`ifdef FEEDER_ERROR_EN
          mErr  = mPend ? 2'b01 : 2'b00;
          mPend = 1'b0;
`else
          mErr = 2'b00;
`endif
          sb.push_back({mErr, mData});
        end else begin
          mValid = 1'b0;
        end
      end
      if (doPush) mFifo.push_back(sample_in);
      if (doDrop) begin
        if (mOvf < 255) mOvf++;
        mPend = 1'b1;
      end
    end
  end

  // Monitor: compares visible state against the model and pops the
  // scoreboard on every handshake that will complete at the next edge.
  always @(negedge clk) begin
    logic [13:0] exp;
    if (monOn) begin
      checkOutput("valid", int'(ast_source_valid), int'(mValid));
      checkOutput("fifoLevel", int'(fifo_level), mFifo.size());
      checkOutput("overflowCnt", int'(overflow_cnt), mOvf);
      if (!mValid) checkOutput("idleError", int'(ast_source_error), 0);
      else checkOutput("heldData", int'(ast_source_data), int'(mData));
      if (reset_n && ast_source_valid && ast_source_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpectedWord", 1, 0);
        end else begin
          exp = sb.pop_front();
          checkOutput("sbData", int'(ast_source_data), int'(exp[11:0]));
          checkOutput("sbError", int'(ast_source_error), int'(exp[13:12]));
        end
      end
    end
  end

  initial begin
    // Reset held for two cycles with strobes active.
    reset_n = 1'b0;
    applyStimulus(1, 12'h7FF, 1);
    monOn = 1'b1;
    applyStimulus(1, 12'h456, 1);
    checkOutput("rstValid", int'(ast_source_valid), 0);
    checkOutput("rstData", int'(ast_source_data), 0);
    checkOutput("rstError", int'(ast_source_error), 0);
    checkOutput("rstLevel", int'(fifo_level), 0);
    checkOutput("rstOvf", int'(overflow_cnt), 0);

    // First sample latency: strobe in cycle 0, valid in cycle 2.
    reset_n = 1'b1;
    applyStimulus(1, 12'h123, 1);
    checkOutput("latCycle1Valid", int'(ast_source_valid), 0);
    applyStimulus(0, 12'h000, 1);
    checkOutput("latCycle2Valid", int'(ast_source_valid), 1);
    checkOutput("latCycle2Data", int'(ast_source_data), 'h123);
    applyStimulus(0, 12'h000, 1);

    // Full-scale ramp streamed at one sample per cycle.
    for (int v = -2048; v <= 2047; v++) begin
      logic [11:0] rv;
      rv = 12'(v);
      applyStimulus(1, rv, 1);
    end
    repeat (4) applyStimulus(0, 12'h000, 1);
    checkOutput("rampOvf", int'(overflow_cnt), 0);

    // Backpressure: nine fit, the tenth is dropped.
    for (int i = 0; i < 9; i++) applyStimulus(1, 12'(i * 37 + 5), 0);
    checkOutput("bpLevel", int'(fifo_level), 8);
    checkOutput("bpValid", int'(ast_source_valid), 1);
    checkOutput("bpHeadData", int'(ast_source_data), 5);
    applyStimulus(1, 12'hABC, 0);
    checkOutput("bpDropOvf", int'(overflow_cnt), 1);
    checkOutput("bpDropLevel", int'(fifo_level), 8);

    // Full FIFO with a simultaneous pop accepts the new sample.
    applyStimulus(1, 12'h5A5, 1);
    checkOutput("fullPopLevel", int'(fifo_level), 8);
    checkOutput("fullPopOvf", int'(overflow_cnt), 1);

    // Saturation of the drop counter, then drain.
    repeat (300) applyStimulus(1, 12'($urandom), 0);
    checkOutput("satOvf", int'(overflow_cnt), 255);
    repeat (12) applyStimulus(0, 12'h000, 1);
    checkOutput("drainLevel", int'(fifo_level), 0);

    // Randomized traffic with a mid-operation reset.
    for (int i = 0; i < 2000; i++) begin
      if (i == 700) reset_n = 1'b0;
      if (i == 702) reset_n = 1'b1;
      applyStimulus($urandom_range(0, 3) != 0, 12'($urandom), $urandom_range(0, 2) != 0);
    end
    repeat (12) applyStimulus(0, 12'h000, 1);

    // Sparse strobes at the audio rate with ready held high.
    for (int s = 0; s < 2; s++) begin
      applyStimulus(1, 12'($urandom), 1);
      repeat (23999) applyStimulus(0, 12'h000, 1);
    end
    checkOutput("endScoreboardEmpty", sb.size(), 0);

    monOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
